// File: rtl/i2s_tx_serializer_pkg.sv
// Shared types and default sizing for the I2S transmit serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_tx_pkg;

  localparam int SCLK_HALF_DEF = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int SLOT_BITS_DEF = 32;
  localparam int FRAME_BITS    = 2 * SLOT_BITS_DEF;
  localparam int BIT_CNT_W     = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } tx_state_t;

endpackage

// File: rtl/i2s_tx_serializer_sclk_gen.sv
// Bit-clock divider: sclk low for the first SCLK_HALF clk of each period, high for the rest.
// Latency: sclk registered; fall strobe is combinational on the clk that wraps the divider.
// Backpressure: none; the divider is frozen at 0 while i_run is low.
module sclk_gen #(
  parameter int SCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_sclk,
  output logic o_fall_stb
);

  localparam int                DIV_W    = $clog2(2 * SCLK_HALF);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(2 * SCLK_HALF - 1);
  localparam logic [DIV_W-1:0]  DIV_RISE = DIV_W'(SCLK_HALF - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_rise_stb;

  // Strobes mark the clk whose edge moves the divider to 0 (fall) or to SCLK_HALF (rise).
  assign o_fall_stb = i_run && (r_div_cnt == DIV_LAST);
  assign w_rise_stb = i_run && (r_div_cnt == DIV_RISE);
  assign o_sclk     = r_sclk;

  // Divider counter and registered bit clock; both parked at 0 when not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      r_div_cnt <= o_fall_stb ? '0 : r_div_cnt + DIV_W'(1);
      if (o_fall_stb) begin
        r_sclk <= 1'b0;
      end else if (w_rise_stb) begin
        r_sclk <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S bus-master transmitter: double-buffers one stereo pair and shifts it out MSB first.
// Latency: vld -> RUN entry 2 clk; left MSB on I2S_data 2*SCLK_HALF clk after RUN entry.
// Backpressure: rdy low while holding buffer full; vld then overwrites and pulses overrun.
module i2s_tx_serializer
  import i2s_tx_pkg::*;
#(
  parameter int SCLK_HALF = SCLK_HALF_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              vld,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rght_in,
  output logic              rdy,
  output logic              smpl_taken,
  output logic              underrun,
  output logic              overrun,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data
);

  localparam int              FRAME    = 2 * SLOT_BITS;
  localparam int              CW       = $clog2(FRAME);
  localparam logic [CW-1:0]   BIT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0]   L_FIRST  = CW'(1);
  localparam logic [CW-1:0]   L_LAST   = CW'(DATA_W);
  localparam logic [CW-1:0]   R_FIRST  = CW'(SLOT_BITS + 1);
  localparam logic [CW-1:0]   R_LAST   = CW'(SLOT_BITS + DATA_W);
  localparam logic [CW-1:0]   WS_RIGHT = CW'(SLOT_BITS);

  tx_state_t         r_state;
  logic [CW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_hold_l, r_hold_r;
  logic [DATA_W-1:0] r_cur_l, r_cur_r;
  logic              r_rdy, r_smpl_taken, r_underrun, r_overrun;
  logic              r_ws, r_data;

  logic              w_fall_stb;
  logic              w_sclk;
  logic [CW-1:0]     w_bit_next;
  logic              w_ws_next, w_data_next;
  logic [DATA_W-1:0] w_sh_l, w_sh_r;
  logic              w_enter, w_last_fall, w_to_idle, w_frame_start;

  sclk_gen #(
    .SCLK_HALF (SCLK_HALF)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (r_state != IDLE),
    .o_sclk     (w_sclk),
    .o_fall_stb (w_fall_stb)
  );

  assign w_bit_next    = r_bit_cnt + CW'(1);
  assign w_enter       = (r_state == IDLE) && en && !r_rdy;
  assign w_last_fall   = w_fall_stb && (r_bit_cnt == BIT_LAST);
  assign w_to_idle     = (r_state == DRAIN) && !en && w_last_fall;
  // A wrap in DRAIN that returns to IDLE is not a frame start.
  assign w_frame_start = w_enter || (w_last_fall && !w_to_idle);

  // Slot map with the one-bit I2S delay: pick the bit that goes out after the next fall.
  always_comb begin
    w_ws_next   = (w_bit_next >= WS_RIGHT);
    w_data_next = 1'b0;
    w_sh_l      = '0;
    w_sh_r      = '0;
    if (w_bit_next >= L_FIRST && w_bit_next <= L_LAST) begin
      w_sh_l      = r_cur_l << (w_bit_next - L_FIRST);
      w_data_next = w_sh_l[DATA_W-1];
    end else if (w_bit_next >= R_FIRST && w_bit_next <= R_LAST) begin
      w_sh_r      = r_cur_r << (w_bit_next - R_FIRST);
      w_data_next = w_sh_r[DATA_W-1];
    end
  end

  // Control FSM, bit counter, double buffer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_cur_l      <= '0;
      r_cur_r      <= '0;
      r_rdy        <= 1'b1;
      r_smpl_taken <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
      r_ws         <= 1'b1;
      r_data       <= 1'b0;
    end else begin
      r_smpl_taken <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_enter) begin
            r_state   <= RUN;
            r_bit_cnt <= '0;
            r_ws      <= 1'b0;
            r_data    <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (w_to_idle) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_ws      <= 1'b1;
            r_data    <= 1'b0;
          end else begin
            r_state <= en ? RUN : DRAIN;
            if (w_fall_stb) begin
              r_bit_cnt <= w_bit_next;
              r_ws      <= w_ws_next;
              r_data    <= w_data_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // Frame start consumes the holding buffer, or replays the last pair if it is empty.
      if (w_frame_start) begin
        r_rdy <= 1'b1;
        if (!r_rdy) begin
          r_cur_l      <= r_hold_l;
          r_cur_r      <= r_hold_r;
          r_smpl_taken <= 1'b1;
        end else begin
          r_underrun <= 1'b1;
        end
      end

      // A new pair always lands; it only counts as overrun if nothing consumed the old one.
      if (vld) begin
        r_hold_l  <= lft_in;
        r_hold_r  <= rght_in;
        r_rdy     <= 1'b0;
        r_overrun <= !r_rdy && !w_frame_start;
      end
    end
  end

  assign rdy        = r_rdy;
  assign smpl_taken = r_smpl_taken;
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;
  assign I2S_sclk   = w_sclk;
  assign I2S_ws     = r_ws;
  assign I2S_data   = r_data;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for the I2S transmit serializer (default parameters).
// Latency: frames are tracked in clk cycles from each frame-start edge (2048 clk per frame).
// Backpressure: exercised through vld timing relative to frame starts.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] lft_in = '0;
  logic [15:0] rght_in = '0;
  logic        rdy, smpl_taken, underrun, overrun;
  logic        I2S_sclk, I2S_ws, I2S_data;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int FRAME_CLK = 2048;

  always #5 clk = ~clk;

  i2s_tx_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .vld        (vld),
    .lft_in     (lft_in),
    .rght_in    (rght_in),
    .rdy        (rdy),
    .smpl_taken (smpl_taken),
    .underrun   (underrun),
    .overrun    (overrun),
    .I2S_sclk   (I2S_sclk),
    .I2S_ws     (I2S_ws),
    .I2S_data   (I2S_data)
  );

  // One record per frame: stimulus during the frame and what the frame must show.
  typedef struct {
    logic        v1;  logic [15:0] l1;  logic [15:0] r1;  // vld at k=500
    logic        v2;  logic [15:0] l2;  logic [15:0] r2;  // vld at k=1000
    logic        vs;  logic [15:0] ls;  logic [15:0] rs;  // vld on next frame-start clk
    int          en_off;                                   // k at which en drops, -1 never
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        e_smpl;
    logic        e_under;
    logic        e_rdy0;
    int          e_ovr;
  } frame_rec_t;

  frame_rec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 16'h0000, r, 15'h0000};
  endfunction

  // Runs one frame starting with the negedge right after its frame-start edge.
  task automatic run_frame(input int i);
    frame_rec_t  t;
    logic [63:0] cd, cw;
    int          nb, n_ovr, n_extra;
    logic        prev_sclk;
    t = tbl[i];
    cd = '0; cw = '0; nb = 0; n_ovr = 0; n_extra = 0;
    prev_sclk = I2S_sclk;
    for (int k = 0; k < FRAME_CLK; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk($sformatf("f%0d_smpl_taken", i), 64'(smpl_taken), 64'(t.e_smpl));
        chk($sformatf("f%0d_underrun", i), 64'(underrun), 64'(t.e_under));
        chk($sformatf("f%0d_overrun_at_start", i), 64'(overrun), 64'(0));
        chk($sformatf("f%0d_rdy_after_start", i), 64'(rdy), 64'(t.e_rdy0));
      end else begin
        if (overrun) n_ovr++;
        if (smpl_taken || underrun) n_extra++;
      end
      if (k == 31) chk($sformatf("f%0d_bit0_data", i), 64'(I2S_data), 64'(0));
      if (k == 32) chk($sformatf("f%0d_msb_timing", i), 64'(I2S_data), 64'(t.exp_l[15]));
      if (I2S_sclk && !prev_sclk) begin
        cd = {cd[62:0], I2S_data};
        cw = {cw[62:0], I2S_ws};
        nb++;
      end
      prev_sclk = I2S_sclk;
      vld = 1'b0;
      if (k == 500 && t.v1) begin vld = 1'b1; lft_in = t.l1; rght_in = t.r1; end
      if (k == 1000 && t.v2) begin vld = 1'b1; lft_in = t.l2; rght_in = t.r2; end
      if (k == FRAME_CLK - 1 && t.vs) begin vld = 1'b1; lft_in = t.ls; rght_in = t.rs; end
      if (k == t.en_off) en = 1'b0;
    end
    chk($sformatf("f%0d_rise_count", i), 64'(nb), 64'(64));
    chk($sformatf("f%0d_data_bits", i), cd, exp_data(t.exp_l, t.exp_r));
    chk($sformatf("f%0d_ws_bits", i), cw, 64'h0000_0000_FFFF_FFFF);
    chk($sformatf("f%0d_overrun_count", i), 64'(n_ovr), 64'(t.e_ovr));
    chk($sformatf("f%0d_extra_pulses", i), 64'(n_extra), 64'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sclk"}, 64'(I2S_sclk), 64'(0));
    chk({tag, "_ws"}, 64'(I2S_ws), 64'(1));
    chk({tag, "_data"}, 64'(I2S_data), 64'(0));
    chk({tag, "_rdy"}, 64'(rdy), 64'(1));
    chk({tag, "_pulses"}, 64'({smpl_taken, underrun, overrun}), 64'(0));
  endtask

  initial begin
    int n_hi;
    int n_pulse;

    //               v1 l1        r1        v2 l2        r2        vs ls        rs        en_off exp_l     exp_r     smpl und rdy0 ovr
    tbl[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, -1, 16'hA5C3, 16'h0F0F, 1'b1, 1'b0, 1'b1, 0};
    tbl[1] = '{1'b1, 16'h1234, 16'h5678, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 16'h0000, 16'h0000, -1, 16'hA5C3, 16'h0F0F, 1'b0, 1'b1, 1'b1, 1};
    tbl[2] = '{1'b1, 16'hC001, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h8001, -1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 0};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, -1, 16'hC001, 16'h0001, 1'b1, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, -1, 16'hFFFF, 16'h8001, 1'b1, 1'b0, 1'b1, 0};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 330, 16'hFFFF, 16'h8001, 1'b0, 1'b1, 1'b1, 0};
    tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, -1, 16'h1357, 16'h2F68, 1'b1, 1'b0, 1'b1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First pair with en: buffer fills on the next edge, RUN one edge after that
    en = 1'b1; vld = 1'b1; lft_in = 16'hA5C3; rght_in = 16'h0F0F;
    @(negedge clk);
    vld = 1'b0;
    chk("first_vld_rdy", 64'(rdy), 64'(0));
    chk("first_vld_no_early_start", 64'(smpl_taken), 64'(0));

    for (int i = 0; i < 6; i++) run_frame(i);

    // After the drained frame: IDLE with static outputs
    @(negedge clk);
    chk("drain_idle_sclk", 64'(I2S_sclk), 64'(0));
    chk("drain_idle_ws", 64'(I2S_ws), 64'(1));
    chk("drain_idle_data", 64'(I2S_data), 64'(0));
    chk("drain_idle_pulses", 64'({smpl_taken, underrun}), 64'(0));
    n_hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (I2S_sclk || !I2S_ws) n_hi++;
    end
    chk("idle_static", 64'(n_hi), 64'(0));

    // Restart from IDLE: vld loads the buffer in IDLE, then RUN from bit 0
    en = 1'b1; vld = 1'b1; lft_in = 16'h1357; rght_in = 16'h2F68;
    @(negedge clk);
    vld = 1'b0;
    chk("restart_rdy", 64'(rdy), 64'(0));
    run_frame(6);

    // Mid-frame async reset at bit_cnt 40 of a replayed frame
    for (int k = 0; k <= 1300; k++) begin
      @(negedge clk);
      if (k == 0) chk("f7_underrun", 64'(underrun), 64'(1));
      vld = 1'b0;
      if (k == 600) begin vld = 1'b1; lft_in = 16'h1111; rght_in = 16'h2222; end
    end
    chk("pre_reset_sclk", 64'(I2S_sclk), 64'(1));
    chk("pre_reset_data", 64'(I2S_data), 64'(1));
    chk("pre_reset_rdy", 64'(rdy), 64'(0));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_hi = 0; n_pulse = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (I2S_sclk) n_hi++;
      if (smpl_taken || underrun || overrun) n_pulse++;
    end
    chk("post_reset_idle_sclk", 64'(n_hi), 64'(0));
    chk("post_reset_idle_pulses", 64'(n_pulse), 64'(0));
    chk_reset_vals("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Back end of the EQ audio path. Accepts one stereo 16-bit sample pair per `vld` strobe, as produced after the EQ sum/volume stage. Double-buffers the pair and serializes it as an I2S bus master, generating `I2S_sclk`, `I2S_ws` and `I2S_data`. It is the transmit-side counterpart of the I2S serf receiver that feeds the EQ engine, used for loopback, external DAC drive, and bench self-check.

Parameters:
- SCLK_HALF, 16, clk cycles per half sclk period (sclk period = 2*SCLK_HALF clk).
- DATA_W, 16, audio sample width, two's complement.
- SLOT_BITS, 32, sclk bits per channel slot; frame = 2*SLOT_BITS bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  transmit enable; level.
- vld  in  1  one-clk strobe, `lft_in`/`rght_in` valid.
- lft_in  in  DATA_W  left sample.
- rght_in  in  DATA_W  right sample.
- rdy  out  1  holding buffer empty.
- smpl_taken  out  1  one-clk pulse, holding buffer moved to shift regs (frame start).
- underrun  out  1  one-clk pulse, frame started with no fresh sample.
- overrun  out  1  one-clk pulse, `vld` while holding buffer full.
- I2S_sclk  out  1  bit clock.
- I2S_ws  out  1  word select: 0 = left, 1 = right.
- I2S_data  out  1  serial data, MSB first.

Behaviour:
- Clock/reset: reset is rst_n, asynchronous, active-low; clock is clk. All outputs registered.
- Reset values: `I2S_sclk`=0, `I2S_ws`=1, `I2S_data`=0, `rdy`=1, pulses=0, state=IDLE, counters=0, buffers=0.
- Divider: `div_cnt` counts 0..2*SCLK_HALF-1.
  - `I2S_sclk`=0 for `div_cnt` < SCLK_HALF, 1 otherwise.
  - fall strobe at `div_cnt` wrap to 0; rise strobe at `div_cnt`==SCLK_HALF.
  - Divider runs only in RUN/DRAIN; held at 0 in IDLE.
- Bit counter `bit_cnt` 0..2*SLOT_BITS-1 advances on each fall strobe.
  - `I2S_ws` and `I2S_data` change only on fall strobes; the receiver samples on sclk rise.
- Slot map (I2S one-bit delay):
  - `ws`=0 for `bit_cnt` 0..SLOT_BITS-1, 1 for SLOT_BITS..2*SLOT_BITS-1.
  - `bit_cnt`=1..DATA_W: left[DATA_W-1..0].
  - `bit_cnt`=SLOT_BITS+1..SLOT_BITS+DATA_W: right[DATA_W-1..0].
  - All other bits drive 0.
- Holding buffer:
  - `vld` loads `lft_in`/`rght_in` and clears `rdy` next clk.
  - `vld` while `rdy`=0 overwrites the buffer and pulses `overrun`.
- Frame start (`bit_cnt` wraps to 0 on a fall strobe, or RUN entry):
  - If `rdy`=0: copy holding to left/right shift regs, set `rdy`=1, pulse `smpl_taken`.
  - If `rdy`=1: reload the previous pair and pulse `underrun`; `smpl_taken` stays 0.
- Simultaneous `vld` and frame-start consume on the same clk: the old buffer content is consumed; the new pair lands in the buffer; `rdy` ends 0; no `overrun`.
- FSM: IDLE, RUN, DRAIN.
  - IDLE -> RUN: `en`=1 and `rdy`=0. Counters are zeroed and the frame start executes on the entry clk.
  - RUN -> DRAIN: `en`=0.
  - DRAIN -> RUN: `en`=1 before frame end.
  - DRAIN -> IDLE: at the last fall strobe of the frame (`bit_cnt`=2*SLOT_BITS-1 wrap). On entry `sclk`=0, `ws`=1, `data`=0; no frame-start actions.
  - In IDLE, `vld` still loads the buffer.
- Latency: the first `vld` with `en`=1 gives RUN entry 2 clk later. Left MSB appears on `I2S_data` 2*SCLK_HALF clk after RUN entry.
- Reset mid-frame: immediate return to reset values; the partial frame is abandoned.

Decomposition:
- Package `i2s_tx_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN} tx_state_t`.
  - Localparams FRAME_BITS = 2*SLOT_BITS and BIT_CNT_W = $clog2(FRAME_BITS).
- Sub-module `sclk_gen`: divider producing `I2S_sclk`, `fall_stb` and `rise_stb` from SCLK_HALF and a run enable.

Test Plan:
- Reset, then `en`=1, `vld` with L=16'hA5C3, R=16'h0F0F -> RUN 2 clk later, `smpl_taken` pulse. Rise-sampled bits 1..16 = A5C3 with `ws`=0; bits 33..48 = 0F0F with `ws`=1; padding bits 0.
- No `vld` after the first frame -> 2nd frame repeats A5C3/0F0F, `underrun` pulses exactly once at frame start, `rdy` stays 1.
- Two `vld` within one frame (1234/5678, then 8000/7FFF) -> `overrun` pulse on the 2nd. Next frame transmits 8000/7FFF.
- `vld` on the exact frame-start clk -> old pair sent, new pair sent next frame, no `overrun`, `rdy`=0 after the frame-start clk.
- `en` dropped at `bit_cnt`=10 -> frame completes all 64 bits, then `sclk` static 0, `ws`=1. Re-assert `en` with `rdy`=0 -> restart at `bit_cnt` 0.
- `rst_n` low at `bit_cnt`=40 -> all outputs at reset values in the same clk (async), IDLE after release.
